// File: rtl/up2axi4l_master_if.sv
// AXI4-Lite bus between up2axi4l_master and a slave.
// Master drives addresses, write data and response readies; the slave drives readies, responses and read data.
interface up2axi4l_master_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/up2axi4l_master.sv
// up_wr/up_rd register bus to AXI4-Lite master; one write and one read slot, round-robin, one AXI transaction at a time.
// Latency: req to ack >= 4 cycles; AXI stalls are waited out indefinitely, and a request to an occupied slot is dropped (sticky up_req_drop).
module up2axi4l_master #(
  parameter int          C_ADDR_WIDTH = 12,
  parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [C_ADDR_WIDTH-3:0] up_wr_addr,
  input  logic                    up_wr_req,
  input  logic [3:0]              up_wr_be,
  input  logic [31:0]             up_wr_din,
  output logic                    up_wr_ack,
  output logic                    up_wr_err,
  input  logic [C_ADDR_WIDTH-3:0] up_rd_addr,
  input  logic                    up_rd_req,
  output logic [31:0]             up_rd_dout,
  output logic                    up_rd_ack,
  output logic                    up_rd_err,
  output logic                    up_req_drop,
  up2axi4l_master_if.master       m_axi
);
  localparam int WA = C_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4
  } state_t;

  typedef struct packed {
    logic [WA-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   din;
  } wr_slot_t;

  state_t        state;
  state_t        state_nxt;
  wr_slot_t      wr_slot;
  logic          wr_vld;
  logic [WA-1:0] rd_addr;
  logic          rd_vld;
  logic          last_wr;
  logic          aw_done;
  logic          w_done;
  logic          wr_elig;
  logic          rd_elig;
  logic          pick_wr;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;
  logic [31:0]   wr_axi_addr;
  logic [31:0]   rd_axi_addr;
  logic          unused_resp;

  // A slot stays valid through its ack cycle so a late request is dropped, but it must not be re-served then.
  assign wr_elig = wr_vld && !up_wr_ack;
  assign rd_elig = rd_vld && !up_rd_ack;
  assign pick_wr = wr_elig && (!rd_elig || !last_wr);

  assign wr_axi_addr = C_BASE_ADDR + 32'({wr_slot.addr, 2'b00});
  assign rd_axi_addr = C_BASE_ADDR + 32'({rd_addr, 2'b00});

  assign aw_hs = (state == WR_ADDR_DATA) && !aw_done && m_axi.awready;
  assign w_hs  = (state == WR_ADDR_DATA) && !w_done && m_axi.wready;
  assign b_hs  = (state == WR_RESP) && m_axi.bvalid;
  assign ar_hs = (state == RD_ADDR) && m_axi.arready;
  assign r_hs  = (state == RD_DATA) && m_axi.rvalid;

  assign unused_resp = ^{m_axi.bresp[0], m_axi.rresp[0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_vld      <= 1'b0;
      wr_slot     <= '0;
      rd_vld      <= 1'b0;
      rd_addr     <= '0;
      up_req_drop <= 1'b0;
    end else begin
      if (up_wr_req && !wr_vld) begin
        wr_vld  <= 1'b1;
        wr_slot <= '{addr: up_wr_addr, be: up_wr_be, din: up_wr_din};
      end else if (up_wr_ack) begin
        wr_vld <= 1'b0;
      end
      if (up_rd_req && !rd_vld) begin
        rd_vld  <= 1'b1;
        rd_addr <= up_rd_addr;
      end else if (up_rd_ack) begin
        rd_vld <= 1'b0;
      end
      if ((up_wr_req && wr_vld) || (up_rd_req && rd_vld)) begin
        up_req_drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_wr) begin
          state_nxt = WR_ADDR_DATA;
        end else if (rd_elig) begin
          state_nxt = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_nxt = IDLE;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axi.awvalid = (state == WR_ADDR_DATA) && !aw_done;
    m_axi.awaddr  = ((state == WR_ADDR_DATA) && !aw_done) ? wr_axi_addr : '0;
    m_axi.awprot  = 3'b000;
    m_axi.wvalid  = (state == WR_ADDR_DATA) && !w_done;
    m_axi.wdata   = ((state == WR_ADDR_DATA) && !w_done) ? wr_slot.din : '0;
    m_axi.wstrb   = ((state == WR_ADDR_DATA) && !w_done) ? wr_slot.be : '0;
    m_axi.bready  = (state == WR_RESP);
    m_axi.arvalid = (state == RD_ADDR);
    m_axi.araddr  = (state == RD_ADDR) ? rd_axi_addr : '0;
    m_axi.arprot  = 3'b000;
    m_axi.rready  = (state == RD_DATA);
  end

  // AW and W complete independently; each done flag holds its valid low until the burst reaches WR_RESP.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      last_wr    <= 1'b0;
      up_wr_ack  <= 1'b0;
      up_wr_err  <= 1'b0;
      up_rd_ack  <= 1'b0;
      up_rd_err  <= 1'b0;
      up_rd_dout <= '0;
    end else begin
      aw_done <= (state == WR_ADDR_DATA) && (state_nxt == WR_ADDR_DATA) && (aw_done || aw_hs);
      w_done  <= (state == WR_ADDR_DATA) && (state_nxt == WR_ADDR_DATA) && (w_done || w_hs);
      if (state == IDLE && state_nxt == WR_ADDR_DATA) begin
        last_wr <= 1'b1;
      end else if (state == IDLE && state_nxt == RD_ADDR) begin
        last_wr <= 1'b0;
      end
      up_wr_ack <= b_hs;
      up_wr_err <= b_hs && m_axi.bresp[1];
      up_rd_ack <= r_hs;
      up_rd_err <= r_hs && m_axi.rresp[1];
      if (r_hs) begin
        up_rd_dout <= m_axi.rdata;
      end
    end
  end
endmodule
